// File: rtl/dds_dac_spi_out.sv
// DAC output stage: picks one DDS waveform, scales it about mid-scale and ships
// each sample as a 16-bit SPI mode-0 frame at a fixed sample rate.
module dds_dac_spi_out #(
  parameter int         SCLK_DIV   = 2,
  parameter int         FRAME_BITS = 16,
  parameter logic [3:0] CMD        = 4'b0011,
  parameter int         SAMPLE_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] wave_sel,
  input  logic [1:0] amp_sel,
  input  logic [7:0] sine_wave,
  input  logic [7:0] square_wave,
  input  logic [7:0] triangle_wave,
  input  logic [7:0] sawtooth_wave,
  output logic [7:0] sample_out,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [HW-1:0]         hcnt, hcnt_nxt;
  logic [BW-1:0]         bcnt, bcnt_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt, frame_word;
  logic [7:0]            wave_mux, scaled, sample_nxt;
  logic                  cs_n_nxt, sclk_nxt, mosi_nxt, done_nxt;

  // Offset-binary -> two's complement, arithmetic shift, back to offset-binary,
  // so attenuation pulls the waveform toward 0x80 rather than toward zero.
  function automatic logic [7:0] scale_sample(input logic [7:0] w, input logic [1:0] sh);
    logic signed [7:0] s;
    logic signed [7:0] r;
    s = signed'(w ^ 8'h80);
    r = s >>> sh;
    return r ^ 8'h80;
  endfunction

  always_comb begin
    case (wave_sel)
      2'b00:   wave_mux = sine_wave;
      2'b01:   wave_mux = square_wave;
      2'b10:   wave_mux = triangle_wave;
      default: wave_mux = sawtooth_wave;
    endcase
  end

  assign scaled     = scale_sample(wave_mux, amp_sel);
  assign frame_word = {CMD, scaled, {(FRAME_BITS-12){1'b0}}};
  assign tick       = (cnt == CNT_LAST);
  assign busy       = (state != IDLE);

  // Free-running sample-rate counter; ticks landing mid-frame are simply ignored.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    bcnt_nxt   = bcnt;
    shreg_nxt  = shreg;
    sample_nxt = sample_out;
    cs_n_nxt   = dac_cs_n;
    sclk_nxt   = dac_sclk;
    mosi_nxt   = dac_mosi;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        if (tick) begin
          state_nxt  = LOAD;
          sample_nxt = scaled;
          shreg_nxt  = frame_word;
          cs_n_nxt   = 1'b0;
          mosi_nxt   = frame_word[FRAME_BITS-1];
        end
      end
      LOAD: begin
        state_nxt = SHIFT;
        hcnt_nxt  = '0;
        bcnt_nxt  = '0;
      end
      SHIFT: begin
        if (hcnt == HALF_LAST) begin
          hcnt_nxt = '0;
          sclk_nxt = ~dac_sclk;
          // Falling edge: present the next bit, or close the frame after the last one.
          if (dac_sclk) begin
            shreg_nxt = shreg << 1;
            mosi_nxt  = shreg[FRAME_BITS-2];
            bcnt_nxt  = bcnt + 1'b1;
            if (bcnt == BIT_LAST) begin
              state_nxt = HOLD;
              cs_n_nxt  = 1'b1;
              sclk_nxt  = 1'b0;
              mosi_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      bcnt       <= '0;
      sample_out <= 8'h80;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hcnt       <= hcnt_nxt;
      bcnt       <= bcnt_nxt;
      sample_out <= sample_nxt;
      dac_cs_n   <= cs_n_nxt;
      dac_sclk   <= sclk_nxt;
      dac_mosi   <= mosi_nxt;
      frame_done <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_dds_dac_spi_out.sv
// Bench for dds_dac_spi_out: an SPI monitor captures each frame and its timing,
// and a plain-arithmetic scaling model supplies the expected payloads.
module tb_dds_dac_spi_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] wave_sel, amp_sel;
  logic [7:0] sine_wave, square_wave, triangle_wave, sawtooth_wave;
  logic [7:0] sample_out;
  logic       dac_cs_n, dac_sclk, dac_mosi, busy, frame_done;

  int checks = 0;
  int errors = 0;

  dds_dac_spi_out dut (
    .clk(clk), .rst(rst), .wave_sel(wave_sel), .amp_sel(amp_sel),
    .sine_wave(sine_wave), .square_wave(square_wave),
    .triangle_wave(triangle_wave), .sawtooth_wave(sawtooth_wave),
    .sample_out(sample_out), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk),
    .dac_mosi(dac_mosi), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // SPI monitor, sampled on the falling clk edge
  int          cyc = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          cs_run = 0, rise_run = 0, busy_run = 0;
  logic [15:0] shift_cap = '0, last_frame = '0;
  int          last_cslen = 0, last_rises = 0, last_busy = 0, last_gap = -1;
  int          done_count = 0, last_done_cyc = 0;
  bit          have_done = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_cs = 1'b1; prev_sclk = 1'b0;
      cs_run = 0; rise_run = 0; busy_run = 0; have_done = 0;
    end else begin
      if (!dac_cs_n) begin
        cs_run++;
        if (!prev_sclk && dac_sclk) begin
          shift_cap = {shift_cap[14:0], dac_mosi};
          rise_run++;
        end
      end else if (!prev_cs) begin
        last_frame = shift_cap; last_cslen = cs_run; last_rises = rise_run;
        cs_run = 0; rise_run = 0;
      end
      if (busy) busy_run++;
      if (frame_done) begin
        last_busy = busy_run;
        done_count++;
        last_gap = have_done ? cyc - last_done_cyc : -1;
        last_done_cyc = cyc;
        have_done = 1;
      end
      if (!busy) busy_run = 0;
      prev_cs = dac_cs_n; prev_sclk = dac_sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offset-binary sample scaled by 2^-amp about 128, rounding toward minus infinity.
  function automatic int ref_scale(input int w, input int amp);
    int o, d;
    o = w - 128;
    d = 1 << amp;
    return ((o >= 0) ? (o / d) : -((-o + d - 1) / d)) + 128;
  endfunction

  function automatic int ref_frame(input int s);
    return (3 << 12) + (s << 4);
  endfunction

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin ok = 1; break; end
    end
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] v0, v1, v2, v3, input logic [1:0] ws, amp);
    sine_wave = v0; square_wave = v1; triangle_wave = v2; sawtooth_wave = v3;
    wave_sel = ws; amp_sel = amp;
  endtask

  // Called just after a frame_done; the inputs set here are captured by the next tick.
  task automatic run_frame(input logic [7:0] v0, v1, v2, v3, input logic [1:0] ws, amp,
                           input bit mid, input string tag);
    int sel, exp_s;
    set_inputs(v0, v1, v2, v3, ws, amp);
    case (ws)
      2'd0: sel = v0;
      2'd1: sel = v1;
      2'd2: sel = v2;
      default: sel = v3;
    endcase
    exp_s = ref_scale(sel, amp);
    if (mid) begin
      for (int i = 0; i < 200 && dac_cs_n !== 1'b0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      #1;
      set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 ws + 2'd1, 2'($urandom));
    end
    wait_done(tag);
    check({tag, "_frame"},  32'(last_frame), 32'(ref_frame(exp_s)));
    check({tag, "_sample"}, 32'(sample_out), 32'(exp_s));
    check({tag, "_cslen"},  32'(last_cslen), 32'd65);
    check({tag, "_rises"},  32'(last_rises), 32'd16);
    check({tag, "_busy"},   32'(last_busy),  32'd66);
    check({tag, "_gap"},    32'(last_gap),   32'd100);
  endtask

  initial begin
    int dc0;
    rst = 1'b1;
    set_inputs(8'hA5, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",   32'(dac_cs_n),   32'd1);
    check("rst_sclk",   32'(dac_sclk),   32'd0);
    check("rst_mosi",   32'(dac_mosi),   32'd0);
    check("rst_sample", 32'(sample_out), 32'h80);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_done",   32'(frame_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    wait_done("a5");
    check("a5_frame",  32'(last_frame), 32'h3A50);
    check("a5_sample", 32'(sample_out), 32'hA5);
    check("a5_cslen",  32'(last_cslen), 32'd65);
    check("a5_rises",  32'(last_rises), 32'd16);
    check("a5_busy",   32'(last_busy),  32'd66);

    for (int ws = 0; ws < 4; ws++)
      run_frame(8'h11, 8'h22, 8'h33, 8'h44, 2'(ws), 2'd0, 0, $sformatf("sel%0d", ws));

    run_frame(8'h00, 8'h00, 8'h00, 8'hFF, 2'd3, 2'd1, 0, "scl_ff_1");
    run_frame(8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 2'd1, 0, "scl_00_1");
    run_frame(8'h00, 8'h00, 8'h00, 8'hFF, 2'd3, 2'd3, 0, "scl_ff_3");
    run_frame(8'h00, 8'h00, 8'h00, 8'h80, 2'd3, 2'd2, 0, "scl_80_2");

    for (int k = 0; k < 8; k++)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom), 2'($urandom), 0, $sformatf("rnd%0d", k));

    run_frame(8'h5A, 8'h3C, 8'hC3, 8'hE7, 2'd2, 2'd1, 1, "mid");

    // Abort the next frame after its fifth sclk rising edge.
    set_inputs(8'h6B, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0);
    for (int i = 0; i < 300 && rise_run < 5; i++) @(negedge clk);
    check("abort_reach5", 32'(rise_run >= 5), 32'd1);
    dc0 = done_count;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", 32'(dac_cs_n),   32'd1);
    check("abort_sclk", 32'(dac_sclk),   32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    set_inputs(8'h00, 8'h00, 8'h9C, 8'h00, 2'd2, 2'd0);
    wait_done("post");
    check("post_frame",  32'(last_frame), 32'(ref_frame(ref_scale(8'h9C, 0))));
    check("post_sample", 32'(sample_out), 32'h9C);
    check("post_cslen",  32'(last_cslen), 32'd65);
    check("post_ndone",  32'(done_count - dc0), 32'd1);

    run_frame(8'hF0, 8'h0F, 8'h77, 8'h01, 2'd1, 2'd2, 0, "post2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
